parameter_update_scheduler: RTL and testbench

PARAMETER_UPDATE_SCHEDULER -- requirements
Module: parameter_update_scheduler

---
 rtl/ioncontrol_pkg.sv | 29 ++
 rtl/param_fifo.sv | 72 +++++++
 rtl/parameter_update_scheduler.sv | 166 ++++++++++++++++
 tb/tb_parameter_update_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioncontrol_pkg.sv
// Shared IonControl definitions for the parameter update path: bus widths,
// deferred-FIFO entry layout, scheduler state encoding and an entry helper.
package ioncontrol_pkg;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 64;
    localparam int ENTRY_W = ADDR_W + DATA_W;
    // Wide enough to hold a count of 16 (largest supported FIFO depth).
    localparam int COUNT_W = 5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } param_entry_t;

    function automatic param_entry_t make_entry(input logic [ADDR_W-1:0] address,
                                                input logic [DATA_W-1:0] data);
        param_entry_t e;
        e.address = address;
        e.data    = data;
        return e;
    endfunction

endpackage

// File: rtl/param_fifo.sv
// Deferred-update FIFO: DEPTH entries of {address,data}, power-of-two depth so
// the pointers wrap naturally. Flush clears pointers and count and overrides
// any same-cycle push or pop. The head entry is presented combinationally.
module param_fifo
    import ioncontrol_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [WIDTH-1:0]   wdata_i,
    output logic [WIDTH-1:0]   rdata_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [COUNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [COUNT_W-1:0] count_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == COUNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/parameter_update_scheduler.sv
// Parameter update scheduler: merges pulse-program writes, host immediate
// writes and committed host deferred writes onto one registered parameter bus.
// Priority per cycle: pulse program, then the host hold register, then a host
// immediate bypass, then the deferred FIFO head while a commit is draining.
module parameter_update_scheduler
    import ioncontrol_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  host_address,
    input  logic [DATA_W-1:0]  host_data,
    input  logic               host_valid,
    input  logic               host_apply_immediately,
    input  logic [ADDR_W-1:0]  pp_address,
    input  logic [DATA_W-1:0]  pp_data,
    input  logic               pp_valid,
    input  logic               commit,
    input  logic               flush,
    output logic [ADDR_W-1:0]  par_address,
    output logic [DATA_W-1:0]  par_data,
    output logic               par_write,
    output logic [COUNT_W-1:0] pending_count,
    output logic               draining,
    output logic               overflow
);

    sched_state_e       state_q;
    logic [COUNT_W-1:0] drain_rem_q;
    logic               hold_valid_q;
    param_entry_t       hold_q;
    logic [ADDR_W-1:0]  par_address_q;
    logic [DATA_W-1:0]  par_data_q;
    logic               par_write_q;
    logic               overflow_q;

    param_entry_t       host_entry;
    param_entry_t       pp_entry;
    param_entry_t       fifo_head;
    param_entry_t       bus_d;
    logic               bus_write_d;
    logic               fifo_full;
    logic               fifo_empty;
    logic [COUNT_W-1:0] fifo_count;
    logic               host_imm;
    logic               host_def;
    logic               drain_start;
    logic               drain_en;
    logic               pop;
    logic               push;
    logic               drop_imm;
    logic               drop_def;
    logic [COUNT_W-1:0] rem_base;
    logic [COUNT_W-1:0] rem_after;

    // Arbitration and FIFO control for the current cycle.
    always_comb begin
        host_entry = make_entry(host_address, host_data);
        pp_entry   = make_entry(pp_address, pp_data);
        host_imm   = host_valid && host_apply_immediately;
        host_def   = host_valid && !host_apply_immediately;

        // A commit starts draining in the same cycle it is seen, so the first
        // entry reaches the bus one cycle after the commit strobe.
        drain_start = (state_q == ST_IDLE) && commit && (fifo_count != '0);
        drain_en    = !flush && ((state_q == ST_DRAIN) || drain_start);
        rem_base    = (state_q == ST_DRAIN) ? drain_rem_q : fifo_count;

        pop       = drain_en && !pp_valid && !hold_valid_q && !host_imm && !fifo_empty;
        rem_after = rem_base - COUNT_W'(pop);

        push     = host_def && !flush && (!fifo_full || pop);
        drop_def = host_def && !flush && fifo_full && !pop;
        // The hold register only stays occupied when pulse program wins.
        drop_imm = host_imm && hold_valid_q && pp_valid;

        bus_write_d = pp_valid || hold_valid_q || host_imm || pop;
        if (pp_valid) begin
            bus_d = pp_entry;
        end else if (hold_valid_q) begin
            bus_d = hold_q;
        end else if (host_imm) begin
            bus_d = host_entry;
        end else begin
            bus_d = fifo_head;
        end
    end

    param_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (host_entry),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Drain state machine: remembers how many entries belong to the commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            drain_rem_q <= '0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            drain_rem_q <= '0;
        end else if (drain_en) begin
            drain_rem_q <= rem_after;
            state_q     <= (rem_after != '0) ? ST_DRAIN : ST_IDLE;
        end
    end

    // One-entry hold for host immediate writes that could not bypass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else if (host_imm && (pp_valid || hold_valid_q) && !drop_imm) begin
            hold_valid_q <= 1'b1;
            hold_q       <= host_entry;
        end else if (hold_valid_q && !pp_valid) begin
            hold_valid_q <= 1'b0;
        end
    end

    // Registered parameter bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_write_q   <= 1'b0;
            par_address_q <= '0;
            par_data_q    <= '0;
        end else begin
            par_write_q <= bus_write_d;
            if (bus_write_d) begin
                par_address_q <= bus_d.address;
                par_data_q    <= bus_d.data;
            end
        end
    end

    // Sticky overflow; flush is the only way to clear it short of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (flush) begin
            overflow_q <= 1'b0;
        end else if (drop_imm || drop_def) begin
            overflow_q <= 1'b1;
        end
    end

    assign par_address   = par_address_q;
    assign par_data      = par_data_q;
    assign par_write     = par_write_q;
    assign pending_count = fifo_count;
    assign draining      = (state_q == ST_DRAIN);
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_parameter_update_scheduler.sv
// Scoreboard bench for parameter_update_scheduler: a queue-based reference
// model steps on every clock edge and queues expected bus writes; a monitor
// compares the bus and status outputs one time unit after each edge.
module tb_parameter_update_scheduler;
    import ioncontrol_pkg::*;

    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [15:0]       host_address = '0;
    logic [63:0]       host_data = '0;
    logic              host_valid = 1'b0;
    logic              host_apply_immediately = 1'b0;
    logic [15:0]       pp_address = '0;
    logic [63:0]       pp_data = '0;
    logic              pp_valid = 1'b0;
    logic              commit = 1'b0;
    logic              flush = 1'b0;
    logic [15:0]       par_address;
    logic [63:0]       par_data;
    logic              par_write;
    logic [4:0]        pending_count;
    logic              draining;
    logic              overflow;

    always #5 clk = ~clk;

    parameter_update_scheduler #(.DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .host_address           (host_address),
        .host_data              (host_data),
        .host_valid             (host_valid),
        .host_apply_immediately (host_apply_immediately),
        .pp_address             (pp_address),
        .pp_data                (pp_data),
        .pp_valid               (pp_valid),
        .commit                 (commit),
        .flush                  (flush),
        .par_address            (par_address),
        .par_data               (par_data),
        .par_write              (par_write),
        .pending_count          (pending_count),
        .draining               (draining),
        .overflow               (overflow)
    );

    typedef struct packed { logic [15:0] a; logic [63:0] d; } ent_t;
    typedef struct packed { logic [15:0] a; logic [63:0] d; int c; } exp_t;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    exp_t obs_q[$];
    ent_t m_fifo[$];
    ent_t m_hold[$];
    bit   m_ovf = 1'b0;
    bit   m_drain = 1'b0;
    int   m_rem = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic issue(input logic [15:0] a, input logic [63:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        e.c = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Reference model: one bus slot per cycle, a capacity-1 hold queue, a
    // bounded deferred queue and a count of entries owed to the active commit.
    task automatic model_step();
        ent_t h;
        ent_t p;
        bit   issued;
        bit   bypass;
        issued = 1'b0;
        bypass = 1'b0;
        h.a = host_address;
        h.d = host_data;
        if (pp_valid) begin
            issue(pp_address, pp_data);
            issued = 1'b1;
        end else if (m_hold.size() != 0) begin
            p = m_hold.pop_front();
            issue(p.a, p.d);
            issued = 1'b1;
        end else if (host_valid && host_apply_immediately) begin
            issue(h.a, h.d);
            issued = 1'b1;
            bypass = 1'b1;
        end
        if (host_valid && host_apply_immediately && !bypass) begin
            if (m_hold.size() == 0) m_hold.push_back(h);
            else m_ovf = 1'b1;
        end
        if (!flush) begin
            if (!m_drain && commit && m_fifo.size() > 0) begin
                m_drain = 1'b1;
                m_rem = m_fifo.size();
            end
            if (m_drain && !issued) begin
                p = m_fifo.pop_front();
                issue(p.a, p.d);
                m_rem = m_rem - 1;
            end
            if (m_rem == 0) m_drain = 1'b0;
            if (host_valid && !host_apply_immediately) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(h);
                else m_ovf = 1'b1;
            end
        end else begin
            m_fifo.delete();
            m_drain = 1'b0;
            m_rem = 0;
            m_ovf = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        if (!reset) model_step();
    end

    // Monitor: pops the scoreboard whenever the bus presents a write.
    initial begin
        exp_t e;
        exp_t o;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
                e = exp_q.pop_front();
                tests++;
                fails++;
                $display("FAIL missing_write cyc %0d: no par_write seen, expected addr %h data %h", e.c, e.a, e.d);
            end
            if (par_write) begin
                o.a = par_address;
                o.d = par_data;
                o.c = cyc;
                obs_q.push_back(o);
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write cyc %0d: got addr %h data %h, expected no write", cyc, par_address, par_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.c != cyc || e.a != par_address || e.d != par_data) begin
                        fails++;
                        $display("FAIL bus_write cyc %0d: got addr %h data %h, expected addr %h data %h at cyc %0d",
                                 cyc, par_address, par_data, e.a, e.d, e.c);
                    end
                end
            end
            tests++;
            if (pending_count != 5'(m_fifo.size()) || overflow != m_ovf || draining != m_drain) begin
                fails++;
                $display("FAIL status cyc %0d: got pending %0d overflow %0b draining %0b, expected %0d %0b %0b",
                         cyc, pending_count, overflow, draining, m_fifo.size(), m_ovf, m_drain);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic chk_obs(input string nm, input int idx, input logic [15:0] a, input int c);
        tests++;
        if (idx >= obs_q.size()) begin
            fails++;
            $display("FAIL %s: write %0d absent, expected addr %h at cyc %0d", nm, idx, a, c);
        end else if (obs_q[idx].a != a || obs_q[idx].c != c) begin
            fails++;
            $display("FAIL %s: write %0d got addr %h cyc %0d, expected addr %h cyc %0d",
                     nm, idx, obs_q[idx].a, obs_q[idx].c, a, c);
        end
    endtask

    task automatic drive(input bit ppv, input logic [15:0] ppa, input logic [63:0] ppd,
                         input bit hv, input bit himm, input logic [15:0] ha, input logic [63:0] hd,
                         input bit cm, input bit fl);
        @(posedge clk);
        #2;
        pp_valid = ppv;
        pp_address = ppa;
        pp_data = ppd;
        host_valid = hv;
        host_apply_immediately = himm;
        host_address = ha;
        host_data = hd;
        commit = cm;
        flush = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 0, 0);
    endtask

    task automatic defer(input logic [15:0] a);
        drive(0, 16'h0, 64'h0, 1, 0, a, {48'hD0D0_0000_0000, a}, 0, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_par_write"}, 64'(par_write), 64'h0);
        chk({tag, "_par_address"}, 64'(par_address), 64'h0);
        chk({tag, "_par_data"}, par_data, 64'h0);
        chk({tag, "_pending_count"}, 64'(pending_count), 64'h0);
        chk({tag, "_draining"}, 64'(draining), 64'h0);
        chk({tag, "_overflow"}, 64'(overflow), 64'h0);
    endtask

    task automatic reset_mid_run();
        @(posedge clk);
        #2;
        pp_valid = 0; host_valid = 0; commit = 0; flush = 0;
        reset = 1'b1;
        #1;
        check_zero_outputs("reset_mid");
        exp_q.delete();
        obs_q.delete();
        m_fifo.delete();
        m_hold.delete();
        m_ovf = 1'b0;
        m_drain = 1'b0;
        m_rem = 0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int c0;
        int ppd;
        #1;
        check_zero_outputs("reset_init");
        #20;
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Pulse-program write reaches the bus one cycle later.
        idle(3);
        obs_q.delete();
        drive(1, 16'h0010, 64'h1122334455667788, 0, 0, 16'h0, 64'h0, 0, 0);
        c0 = cyc;
        idle(3);
        chk_obs("pp_latency", 0, 16'h0010, c0 + 1);
        if (obs_q.size() > 0) chk("pp_data", obs_q[0].d, 64'h1122334455667788);

        // Three deferred writes drained on consecutive cycles after commit.
        defer(16'h0001); defer(16'h0002); defer(16'h0003);
        idle(1);
        chk("pending_before_commit", 64'(pending_count), 64'd3);
        obs_q.delete();
        drive(0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 1, 0);
        c0 = cyc;
        idle(5);
        chk_obs("drain_1", 0, 16'h0001, c0 + 1);
        chk_obs("drain_2", 1, 16'h0002, c0 + 2);
        chk_obs("drain_3", 2, 16'h0003, c0 + 3);
        chk("drain_done", 64'(draining), 64'h0);

        // Pulse program pre-empts the second pop.
        defer(16'h0001); defer(16'h0002); defer(16'h0003);
        idle(1);
        obs_q.delete();
        drive(0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 1, 0);
        c0 = cyc;
        drive(1, 16'h0020, 64'hABCD, 0, 0, 16'h0, 64'h0, 0, 0);
        idle(6);
        chk_obs("preempt_1", 0, 16'h0001, c0 + 1);
        chk_obs("preempt_pp", 1, 16'h0020, c0 + 2);
        chk_obs("preempt_2", 2, 16'h0002, c0 + 3);
        chk_obs("preempt_3", 3, 16'h0003, c0 + 4);

        // Overfill the FIFO, then flush.
        obs_q.delete();
        for (int i = 0; i <= DEPTH; i++) defer(16'(16'h0100 + i));
        idle(1);
        chk("full_pending", 64'(pending_count), 64'(DEPTH));
        chk("full_overflow", 64'(overflow), 64'h1);
        drive(0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 0, 1);
        idle(3);
        chk("flush_pending", 64'(pending_count), 64'h0);
        chk("flush_overflow", 64'(overflow), 64'h0);
        chk("flush_no_write", 64'(obs_q.size()), 64'h0);

        // Same-cycle pulse program and host immediate.
        obs_q.delete();
        drive(1, 16'h0077, 64'h77, 1, 1, 16'h0005, 64'h55, 0, 0);
        c0 = cyc;
        idle(3);
        chk_obs("pp_first", 0, 16'h0077, c0 + 1);
        chk_obs("host_held", 1, 16'h0005, c0 + 2);

        // Reset during a drain with four pending.
        defer(16'h0041); defer(16'h0042); defer(16'h0043); defer(16'h0044);
        drive(0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 1, 0);
        reset_mid_run();
        idle(10);
        chk("reset_no_write", 64'(obs_q.size()), 64'h0);

        // Randomized traffic: a light and a pulse-program-heavy phase.
        for (int ph = 0; ph < 2; ph++) begin
            ppd = (ph == 0) ? 7 : 2;
            for (int i = 0; i < 1500; i++) begin
                drive($urandom_range(ppd) == 0, 16'($urandom), {$urandom, $urandom},
                      $urandom_range(2) != 0, 1'($urandom_range(1)), 16'($urandom), {$urandom, $urandom},
                      $urandom_range(9) == 0, $urandom_range(79) == 0);
            end
        end
        drive(0, 16'h0, 64'h0, 0, 0, 16'h0, 64'h0, 0, 1);
        idle(30);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
